fifo_rr_push_arbiter: RTL
=========================

# fifo_rr_push_arbiter

Round-robin, packet-aware write arbiter that shares one flip-flop FIFO write port between several requesters. It sits directly in front of the FIFO, observes the FIFO's `full` and `pop`, and drives its `push`/`write_data`. Once a requester wins arbitration, it keeps the FIFO until it delivers the last beat of its packet. This keeps packets contiguous inside the FIFO.

## Interface
- `n_req`, default 4: number of requesters, ≥ 2.
- `width`, default 8: data width, matches the FIFO `width`.
- `allow_push_when_full_with_pop`, default 1: when 1, a push is legal while `fifo_full` is high if `fifo_pop` is high in the same cycle.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  n_req  per-requester valid; bit i means requester i offers a beat.
- `req_last`  in  n_req  per-requester end-of-packet flag, qualified by `req[i]`.
- `req_data`  in  n_req*width  flattened data; requester i occupies bits [i*width +: width].
- `gnt`  out  n_req  one-hot or zero; `gnt[i]` means requester i's beat is accepted this cycle.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_pop`  in  1  FIFO pop in the current cycle.
- `fifo_push`  out  1  push to the FIFO.
- `fifo_write_data`  out  width  data to the FIFO.
- `locked`  out  1  high while a multi-beat packet owns the port.
- `owner`  out  $clog2(n_req)  current or most recent owner index.

## Operation
- `can_push` = `~fifo_full | (allow_push_when_full_with_pop & fifo_pop)`.
- **State IDLE:**
  - The candidate is the first i with `req[i]`=1, searching upward from `ptr` and wrapping modulo `n_req`.
  - If a candidate exists and `can_push` is 1, then `gnt[candidate]`=1 and `fifo_push`=1.
  - If the granted beat has `req_last`=1, stay in IDLE and set `ptr` to candidate+1 mod `n_req`.
  - If the granted beat has `req_last`=0, go to LOCKED with `owner` set to the candidate.
- **State LOCKED:**
  - Only `owner` can be granted: `gnt[owner]` = `req[owner] & can_push`.
  - Other requests are ignored, even when `req[owner]`=0; the result is a bubble, not a handoff.
  - On an accepted beat with `req_last[owner]`=1, go to IDLE and set `ptr` to owner+1 mod `n_req`.
- `fifo_write_data` = `req_data` slice of the granted index when `fifo_push`=1. Otherwise it is the slice at `owner`; that value is don't-care, but must be free of X after reset.
- A requester holds `req`, `req_last` and its data stable until granted. The arbiter does not check this.
- Pointer arithmetic is modulo `n_req`, and `n_req` need not be a power of 2. The wrap from `n_req`-1 goes to 0.
- Single-beat packets (`req_last`=1 on the first beat) never enter LOCKED.

## Timing
- `gnt`, `fifo_push` and `fifo_write_data` are combinational from `req`, `req_last`, `fifo_full`, `fifo_pop` and state. There are zero cycles of latency from request to push.
- `state`, `ptr` and `owner` update on the `clk` edge after an accepted beat. `locked` is registered and equals (state == LOCKED).
- Reset values: state IDLE, `ptr`=0, `owner`=0, `locked`=0. With `req`=0, `gnt`=0 and `fifo_push`=0.
- When `fifo_full`=1 and `fifo_pop`=0, `gnt`=0 regardless of state, and state is unchanged.
- When full with pop and `allow_push_when_full_with_pop`=1, the grant proceeds. With the parameter at 0, `gnt`=0.
- If `rst` asserts mid-packet, the block returns to IDLE immediately (asynchronously). Any partial packet already in the FIFO is the system's responsibility.
- Any number of simultaneous requests produces at most one grant per cycle.

## Structure
- Package `fifo_rr_push_arbiter_pkg` holds the state enum `arb_state_t` {ARB_IDLE, ARB_LOCKED}.
- Sub-module `rr_priority_select`: a combinational rotate-and-find-first over `n_req` bits. It has inputs `req` and `ptr`, and outputs `found` and `index`.
- The top module holds the state register, `ptr`, `owner`, the `can_push` logic and the data mux.
- The bench instantiates the arbiter with `flip_flop_fifo_empty_full_optimized` (`depth`=5) and `fifo_monitor`.

## Test plan
- **Reset:** assert `rst` for 3 cycles with `req`=4'b1111. Required: `gnt`=0 during reset. After release, the first grant goes to index 0 and `ptr`=1.
- **Round robin:** hold `req`=4'b1111 with all `req_last`=1 and `fifo_pop`=1 continuously. Required: grants cycle 0,1,2,3,0 on consecutive cycles, and the FIFO reads back 0x00, 0x11, 0x22, 0x33.
- **Packet lock:** requester 2 sends 3 beats (last on beat 3) while requester 1 holds `req`. Required: `gnt`=4'b0100 for 3 accepted beats, `locked`=1 after beat 1, then `gnt`=4'b0010.
- **Owner bubble:** in LOCKED, the owner drops `req` for 2 cycles while others request. Required: `gnt`=0 for both cycles and `owner` unchanged.
- **Full boundary:** fill the FIFO (5 beats, no pop). Required: `gnt`=0 while `fifo_full`=1. Then pulse `fifo_pop`: required a push in the same cycle, and the monitor reports no overflow.
- **Reset mid-packet:** assert `rst` after beat 2 of 4. Required: `locked`=0 and `ptr`=0 immediately, and the next grant follows IDLE priority from index 0.

Source files
------------

// File: rtl/fifo_rr_push_arbiter_pkg.sv
// Shared types and helpers for the round-robin, packet-aware FIFO push arbiter.
package fifo_rr_push_arbiter_pkg;

  // Arbiter ownership state: free arbitration or locked to one packet owner.
  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Increment an index modulo n (n need not be a power of two).
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    int unsigned nxt;
    nxt = idx + 32'd1;
    return (nxt >= n) ? 32'd0 : nxt;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Rotate-and-find-first: lowest set req bit at or above ptr, else lowest set bit overall.
module rr_priority_select
  import fifo_rr_push_arbiter_pkg::*;
#(
  parameter int unsigned n_req = 4
) (
  input  logic [n_req-1:0]         req,
  input  logic [$clog2(n_req)-1:0] ptr,
  output logic                     found,
  output logic [$clog2(n_req)-1:0] index
);

  localparam int unsigned IDX_W = $clog2(n_req);

  logic             hi_found;
  logic [IDX_W-1:0] hi_index;

  // Descending scan: last hit wins, so both the wrap-around and the at-or-above-ptr
  // candidates end up holding the lowest qualifying index.
  always_comb begin
    found    = 1'b0;
    index    = '0;
    hi_found = 1'b0;
    hi_index = '0;
    for (int unsigned i = n_req; i > 0; i--) begin
      if (req[i-1]) begin
        found = 1'b1;
        index = IDX_W'(i - 32'd1);
        if ((i - 32'd1) >= 32'(ptr)) begin
          hi_found = 1'b1;
          hi_index = IDX_W'(i - 32'd1);
        end
      end
    end
    if (hi_found) begin
      index = hi_index;
    end
  end

endmodule

// File: rtl/fifo_rr_push_arbiter.sv
// Round-robin write arbiter in front of a FIFO; a winner keeps the port until its last beat.
module fifo_rr_push_arbiter
  import fifo_rr_push_arbiter_pkg::*;
#(
  parameter int unsigned n_req                         = 4,
  parameter int unsigned width                         = 8,
  parameter bit          allow_push_when_full_with_pop = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [n_req-1:0]         req,
  input  logic [n_req-1:0]         req_last,
  input  logic [n_req*width-1:0]   req_data,
  output logic [n_req-1:0]         gnt,
  input  logic                     fifo_full,
  input  logic                     fifo_pop,
  output logic                     fifo_push,
  output logic [width-1:0]         fifo_write_data,
  output logic                     locked,
  output logic [$clog2(n_req)-1:0] owner
);

  localparam int unsigned IDX_W = $clog2(n_req);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic             locked_q, locked_d;

  logic             can_push_c;
  logic             sel_found_c;
  logic [IDX_W-1:0] sel_index_c;
  logic [IDX_W-1:0] grant_idx_c;

  // Round-robin candidate search starting at ptr.
  rr_priority_select #(
    .n_req(n_req)
  ) u_select (
    .req  (req),
    .ptr  (ptr_q),
    .found(sel_found_c),
    .index(sel_index_c)
  );

  // A push is legal when the FIFO has room, or (optionally) when it frees a slot this cycle.
  assign can_push_c = ~fifo_full | (allow_push_when_full_with_pop & fifo_pop);

  // Grant decode and next-state; grants are suppressed entirely while reset is held.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    gnt         = '0;
    fifo_push   = 1'b0;
    grant_idx_c = owner_q;

    if (!rst) begin
      unique case (state_q)
        ARB_IDLE: begin
          if (sel_found_c && can_push_c) begin
            gnt[sel_index_c] = 1'b1;
            fifo_push        = 1'b1;
            grant_idx_c      = sel_index_c;
            if (req_last[sel_index_c]) begin
              ptr_d = IDX_W'(wrap_inc(32'(sel_index_c), n_req));
            end else begin
              state_d = ARB_LOCKED;
              owner_d = sel_index_c;
            end
          end
        end
        ARB_LOCKED: begin
          // Only the owner may push; a silent owner produces a bubble, never a handoff.
          if (req[owner_q] && can_push_c) begin
            gnt[owner_q] = 1'b1;
            fifo_push    = 1'b1;
            grant_idx_c  = owner_q;
            if (req_last[owner_q]) begin
              state_d = ARB_IDLE;
              ptr_d   = IDX_W'(wrap_inc(32'(owner_q), n_req));
            end
          end
        end
        default: begin
          state_d = ARB_IDLE;
        end
      endcase
    end

    locked_d = (state_d == ARB_LOCKED);
  end

  // Write-data mux: granted slice when pushing, otherwise the owner's slice (X-free after reset).
  always_comb begin
    fifo_write_data = '0;
    for (int unsigned i = 0; i < n_req; i++) begin
      if (IDX_W'(i) == grant_idx_c) begin
        fifo_write_data = req_data[i*width +: width];
      end
    end
  end

  // State, round-robin pointer, owner and registered lock flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      locked_q <= locked_d;
    end
  end

  assign locked = locked_q;
  assign owner  = owner_q;

endmodule
